// File: rtl/reset_sequencer.sv
// Filters and synchronises PLL lock, holds every reset, then releases reset_out[0..NUM_RST-1] STAGE_GAP apart.
// Lock rise to reset_out[0] fall: SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES+1 cycles; lock loss re-asserts in SYNC_STAGES+1.
module reset_sequencer #(
    parameter int NUM_RST     = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int STAGE_GAP   = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    input  logic               sticky_clr,
    output logic [NUM_RST-1:0] reset_out,
    output logic               all_released,
    output logic               lock_lost_sticky
);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lk_sync;
    logic                   lk_s;
    logic [FW-1:0]          filt_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [SW-1:0]          stage_cnt;
    logic [GW-1:0]          gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_sync <= '0;
        end else begin
            lk_sync <= {lk_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk_s = lk_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= WAIT_LOCK;
            reset_out        <= '1;
            all_released     <= 1'b0;
            lock_lost_sticky <= 1'b0;
            filt_cnt         <= '0;
            hold_cnt         <= '0;
            stage_cnt        <= '0;
            gap_cnt          <= '0;
        end else begin
            // A lock-loss set below overrides this clear in the same cycle.
            if (sticky_clr) lock_lost_sticky <= 1'b0;

            if (state != WAIT_LOCK && !lk_s) begin
                state            <= WAIT_LOCK;
                reset_out        <= '1;
                all_released     <= 1'b0;
                lock_lost_sticky <= 1'b1;
                filt_cnt         <= '0;
                hold_cnt         <= '0;
                stage_cnt        <= '0;
                gap_cnt          <= '0;
            end else if (state != WAIT_LOCK && soft_reset_req) begin
                state        <= HOLD;
                reset_out    <= '1;
                all_released <= 1'b0;
                hold_cnt     <= '0;
                stage_cnt    <= '0;
                gap_cnt      <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        // Lock is accepted on the sample after LOCK_FILTER consecutive highs.
                        if (!lk_s) begin
                            filt_cnt <= '0;
                        end else if (filt_cnt == FILT_LAST) begin
                            state    <= HOLD;
                            filt_cnt <= '0;
                            hold_cnt <= '0;
                        end else begin
                            filt_cnt <= filt_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt     <= '0;
                            stage_cnt    <= '0;
                            gap_cnt      <= '0;
                            reset_out[0] <= 1'b0;
                            if (NUM_RST == 1) begin
                                state        <= RUN;
                                all_released <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt   <= '0;
                            stage_cnt <= stage_cnt + 1'b1;
                            for (int i = 1; i < NUM_RST; i++) begin
                                if (i == int'(stage_cnt) + 1) reset_out[i] <= 1'b0;
                            end
                            if (int'(stage_cnt) + 2 == NUM_RST) begin
                                state        <= RUN;
                                all_released <= 1'b1;
                                stage_cnt    <= '0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end
endmodule
